// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
//   in_*  : operand beat (valid/ready), opcode and accumulate select
//   out_* : result beat (valid/ready), result and status flags
//   op_count : delivered-result counter
// master = producer/consumer side (bench or upstream), slave = the unit.
interface logic_unit_pipe_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             in_acc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_ones;
   logic             out_parity;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, in_a, in_b, in_op, in_acc, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_ones, out_parity, op_count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_ones, out_parity, op_count
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with optional accumulate chaining.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   lu   : slave side of logic_unit_pipe_if (operand beat in, result beat out,
//          zero/ones/parity flags, delivered-result counter)
// Stage 1 computes op(A,B) and updates the accumulator; stage 2 is the output
// register with flags. in_ready is combinational from out_ready.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   logic_unit_pipe_if.slave  lu
);
   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOR  = 3'd2,
      OP_XOR  = 3'd3,
      OP_XNOR = 3'd4,
      OP_NAND = 3'd5,
      OP_NOTA = 3'd6,
      OP_PASSB= 3'd7
   } op_e;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_res_q,   s1_res_d;
   logic [WIDTH-1:0] acc_q,      acc_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_res_q,  out_res_d;
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;
   logic             par_q,  par_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;

   logic             s2_free_c;
   logic             s1_adv_c;
   logic             accept_c;
   logic [WIDTH-1:0] opa_c;
   logic [WIDTH-1:0] res_c;

   // Handshake qualifiers
   assign s2_free_c = !out_valid_q || lu.out_ready;
   assign s1_adv_c  = s1_valid_q && s2_free_c;
   assign lu.in_ready = !s1_valid_q || s2_free_c;
   assign accept_c  = lu.in_valid && lu.in_ready;

   // Bitwise operation on the selected A operand
   always_comb begin
      opa_c = lu.in_acc ? acc_q : lu.in_a;
      res_c = '0;
      unique case (op_e'(lu.in_op))
         OP_AND:   res_c = opa_c & lu.in_b;
         OP_OR:    res_c = opa_c | lu.in_b;
         OP_NOR:   res_c = ~(opa_c | lu.in_b);
         OP_XOR:   res_c = opa_c ^ lu.in_b;
         OP_XNOR:  res_c = ~(opa_c ^ lu.in_b);
         OP_NAND:  res_c = ~(opa_c & lu.in_b);
         OP_NOTA:  res_c = ~opa_c;
         OP_PASSB: res_c = lu.in_b;
         default:  res_c = '0;
      endcase
   end

   // Next-state for both stages, accumulator and counter
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_res_d    = s1_res_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_res_d   = out_res_q;
      zero_d      = zero_q;
      ones_d      = ones_q;
      par_d       = par_q;
      cnt_d       = cnt_q;

      // A new beat may enter s1 in the same cycle the old one leaves it
      if (accept_c) begin
         s1_valid_d = 1'b1;
         s1_res_d   = res_c;
         acc_d      = res_c;
      end else if (s1_adv_c) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv_c) begin
         out_valid_d = 1'b1;
         out_res_d   = s1_res_q;
         zero_d      = (s1_res_q == '0);
         ones_d      = (s1_res_q == '1);
         par_d       = ^s1_res_q;
      end else if (lu.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (out_valid_q && lu.out_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_res_q    <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         zero_q      <= 1'b0;
         ones_q      <= 1'b0;
         par_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_res_q    <= s1_res_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
         zero_q      <= zero_d;
         ones_q      <= ones_d;
         par_q       <= par_d;
         cnt_q       <= cnt_d;
      end
   end

   assign lu.out_valid  = out_valid_q;
   assign lu.out_result = out_res_q;
   assign lu.out_zero   = zero_q;
   assign lu.out_ones   = ones_q;
   assign lu.out_parity = par_q;
   assign lu.op_count   = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_logic_unit_pipe;
   localparam int unsigned W  = 16;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic_unit_pipe_if #(.WIDTH(W), .CNT_W(CW)) lu ();

   logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .lu  (lu)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] m_acc;
   int           m_cnt;
   int           delivered;

   logic         o_valid, o_rdy, o_zero, o_ones, o_par;
   logic [W-1:0] o_res;

   typedef struct {
      logic [2:0]   op;
      logic         acc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         zero;
      logic         ones;
      logic         par;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return ~(a | b);
         3:       return a ^ b;
         4:       return ~(a ^ b);
         5:       return ~(a & b);
         6:       return ~a;
         default: return b;
      endcase
   endfunction

   // One cycle: drive at negedge, observe/score just after, then the edge follows
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic acc, input logic ordy);
      logic [W-1:0] r;
      @(negedge clk);
      lu.in_valid  = v;
      lu.in_a      = a;
      lu.in_b      = b;
      lu.in_op     = op;
      lu.in_acc    = acc;
      lu.out_ready = ordy;
      #1;
      o_valid = lu.out_valid;
      o_rdy   = lu.in_ready;
      o_res   = lu.out_result;
      o_zero  = lu.out_zero;
      o_ones  = lu.out_ones;
      o_par   = lu.out_parity;
      chk("op_count", 32'(lu.op_count), 32'(m_cnt % 16));
      chk("in_ready", 32'(o_rdy), 32'((q.size() < 2) || ordy));
      if (o_valid && ordy) begin
         if (q.size() == 0) begin
            chk("out_valid_without_beat", 32'(o_valid), 32'd0);
         end else begin
            r = q.pop_front();
            chk("result_order", 32'(o_res), 32'(r));
            chk("flags", {29'd0, o_zero, o_ones, o_par},
                {29'd0, (r == 0), (r == {W{1'b1}}), ($countones(r) % 2 == 1)});
            m_cnt++;
            delivered++;
         end
      end
      if (v && o_rdy) begin
         r = ref_op(int'(op), acc ? m_acc : a, b);
         q.push_back(r);
         m_acc = r;
      end
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, 3'd0, 1'b0, ordy);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
      chk("drain_left", 32'(q.size()), 32'd0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      lu.in_valid = 1'b0;
      #1;
      chk("rst_out_valid", 32'(lu.out_valid), 32'd0);
      chk("rst_op_count", 32'(lu.op_count), 32'd0);
      q.delete();
      m_acc = '0;
      m_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tbl[10];
   int   d0;

   initial begin
      lu.in_valid = 1'b0; lu.in_a = '0; lu.in_b = '0; lu.in_op = '0;
      lu.in_acc = 1'b0; lu.out_ready = 1'b1;
      m_acc = '0; m_cnt = 0; delivered = 0;

      #1;
      chk("reset_out_valid", 32'(lu.out_valid), 32'd0);
      chk("reset_result", 32'(lu.out_result), 32'd0);
      chk("reset_flags", {29'd0, lu.out_zero, lu.out_ones, lu.out_parity}, 32'd0);
      chk("reset_op_count", 32'(lu.op_count), 32'd0);
      chk("reset_in_ready", 32'(lu.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // op acc a b -> res zero ones parity
      tbl[0] = '{3'd1, 1'b0, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{3'd3, 1'b0, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{3'd4, 1'b0, 16'hA5A5, 16'hA5A5, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{3'd5, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{3'd0, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{3'd2, 1'b0, 16'h00FF, 16'h0F00, 16'hF000, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{3'd6, 1'b0, 16'h1234, 16'h5A5A, 16'hEDCB, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{3'd7, 1'b0, 16'hFFFF, 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{3'd3, 1'b1, 16'h7777, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{3'd0, 1'b1, 16'h0000, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b1};

      foreach (tbl[i]) begin
         step(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].acc, 1'b1);
         idle(1'b1);
         chk("tbl_lat_early", 32'(o_valid), 32'd0);
         idle(1'b1);
         chk("tbl_lat_valid", 32'(o_valid), 32'd1);
         chk("tbl_result", 32'(o_res), 32'(tbl[i].res));
         chk("tbl_flags", {29'd0, o_zero, o_ones, o_par},
             {29'd0, tbl[i].zero, tbl[i].ones, tbl[i].par});
      end

      // Back-to-back accumulate chain
      step(1'b1, 16'h1234, 16'h0000, 3'd3, 1'b0, 1'b1);
      step(1'b1, 16'hBEEF, 16'h00FF, 3'd3, 1'b1, 1'b1);
      step(1'b1, 16'hBEEF, 16'h0000, 3'd6, 1'b1, 1'b1);
      chk("acc_beat1", 32'(o_res), 32'h1234);
      idle(1'b1);
      chk("acc_beat2", 32'(o_res), 32'h12CB);
      idle(1'b1);
      chk("acc_beat3", 32'(o_res), 32'hED34);
      drain();

      // Backpressure: third beat must wait, output must hold
      d0 = delivered;
      step(1'b1, '0, 16'h1111, 3'd7, 1'b0, 1'b0);
      step(1'b1, '0, 16'h2222, 3'd7, 1'b0, 1'b0);
      step(1'b1, '0, 16'h3333, 3'd7, 1'b0, 1'b0);
      chk("bp_in_ready_low", 32'(o_rdy), 32'd0);
      chk("bp_held_a", 32'(o_res), 32'h1111);
      step(1'b1, '0, 16'h3333, 3'd7, 1'b0, 1'b0);
      chk("bp_held_b", 32'(o_res), 32'h1111);
      step(1'b1, '0, 16'h3333, 3'd7, 1'b0, 1'b1);
      chk("bp_release_ready", 32'(o_rdy), 32'd1);
      drain();
      chk("bp_delivered", 32'(delivered - d0), 32'd3);

      // Counter wrap: 17 deliveries from zero end at 1
      do_reset();
      for (int i = 0; i < 17; i++)
         step(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b1);
      drain();
      idle(1'b1);
      chk("cnt_wrap_final", 32'(lu.op_count), 32'd1);

      // Reset with two beats buffered, then accumulate from a cleared acc
      step(1'b1, 16'h1111, 16'h0101, 3'd1, 1'b0, 1'b0);
      step(1'b1, 16'h2222, 16'h0202, 3'd1, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 16'hFFFF, 16'h0F0F, 3'd3, 1'b1, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("post_rst_valid", 32'(o_valid), 32'd1);
      chk("post_rst_acc", 32'(o_res), 32'h0F0F);
      drain();

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 3'($urandom),
              1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 7));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
